// File: rtl/phase_acc_bank.sv
// Per-operator phase accumulator bank: walks every slot once per sample frame,
// adds the upstream (signed) increment and emits the phase MSBs. Optional PHASE_MOD_EN adds phase_mod to the output.
`timescale 1ns/1ps

module phase_acc_bank #(
  parameter int unsigned NUM_OPS         = 18,
  parameter int unsigned PHASE_ACC_WIDTH = 20,
  parameter int unsigned PHASE_OUT_WIDTH = 10
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          sample_clk_en,
  input  logic [NUM_OPS-1:0]                            key_on,
  output logic [((NUM_OPS > 1) ? $clog2(NUM_OPS) : 1)-1:0] slot_req,
  input  logic signed [PHASE_ACC_WIDTH-1:0]             phase_inc,
`ifdef PHASE_MOD_EN
  input  logic signed [PHASE_OUT_WIDTH-1:0]             phase_mod,
`endif
  output logic [PHASE_OUT_WIDTH-1:0]                    phase_out,
  output logic [((NUM_OPS > 1) ? $clog2(NUM_OPS) : 1)-1:0] phase_slot,
  output logic                                          phase_valid,
  output logic                                          busy,
  output logic                                          overrun
);

  localparam int unsigned SLOT_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [SLOT_W-1:0]          r_cnt;
  logic [SLOT_W-1:0]          w_cnt_nxt;
  logic [SLOT_W-1:0]          r_slot_req;
  logic [SLOT_W-1:0]          w_req_nxt;
  logic                       w_wr;
  logic                       w_last;
  logic [PHASE_ACC_WIDTH-1:0] r_acc [NUM_OPS];
  logic [NUM_OPS-1:0]         r_prev_ko;
  logic [PHASE_OUT_WIDTH-1:0] r_phase_out;
  logic [SLOT_W-1:0]          r_phase_slot;
  logic                       r_phase_valid;
  logic                       r_busy;
  logic                       r_overrun;
  logic                       w_ko_edge;
  logic [PHASE_ACC_WIDTH-1:0] w_acc_new;
  logic [PHASE_OUT_WIDTH-1:0] w_phase_new;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, slot sequencing and write enable
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_slot_req;
    w_wr        = 1'b0;
    w_last      = (r_cnt == SLOT_W'(NUM_OPS - 1));
    case (r_state)
      ST_IDLE: begin
        if (sample_clk_en) begin
          w_state_nxt = ST_READ;
          w_cnt_nxt   = '0;
          w_req_nxt   = '0;
        end
      end
      ST_READ: begin
        w_state_nxt = ST_WRITE;
        w_req_nxt   = r_cnt;
      end
      ST_WRITE: begin
        w_wr = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_READ;
          w_cnt_nxt   = r_cnt + SLOT_W'(1);
          w_req_nxt   = r_cnt + SLOT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A rising key_on restarts the slot at phase zero instead of accumulating
  always_comb begin
    w_ko_edge = key_on[r_cnt] & ~r_prev_ko[r_cnt];
    w_acc_new = w_ko_edge ? '0 : (r_acc[r_cnt] + $unsigned(phase_inc));
`ifdef PHASE_MOD_EN
    w_phase_new = w_acc_new[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH] + $unsigned(phase_mod);
`else
    w_phase_new = w_acc_new[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH];
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_slot_req    <= '0;
      r_prev_ko     <= '0;
      r_phase_out   <= '0;
      r_phase_slot  <= '0;
      r_phase_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      for (int s = 0; s < int'(NUM_OPS); s++) r_acc[s] <= '0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_slot_req    <= w_req_nxt;
      r_phase_valid <= w_wr;
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_overrun     <= sample_clk_en & (r_state != ST_IDLE);
      if (w_wr) begin
        r_acc[r_cnt]     <= w_acc_new;
        r_prev_ko[r_cnt] <= key_on[r_cnt];
        r_phase_out      <= w_phase_new;
        r_phase_slot     <= r_cnt;
      end
    end
  end

  assign slot_req    = r_slot_req;
  assign phase_out   = r_phase_out;
  assign phase_slot  = r_phase_slot;
  assign phase_valid = r_phase_valid;
  assign busy        = r_busy;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_phase_acc_bank.sv
// Directed self-checking bench for phase_acc_bank; inputs change and outputs are sampled on negedge.
`timescale 1ns/1ps

module tb_phase_acc_bank;

  localparam int NOPS = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_clk_en = 1'b0;
  logic [17:0] key_on = '0;
  logic [4:0]  slot_req;
  logic signed [19:0] phase_inc;
  logic [9:0]  phase_out;
  logic [4:0]  phase_slot;
  logic        phase_valid;
  logic        busy;
  logic        overrun;
`ifdef PHASE_MOD_EN
  logic signed [9:0] phase_mod = '0;
`endif

  logic [19:0] inc_tab [NOPS];
  assign phase_inc = inc_tab[slot_req];

  phase_acc_bank dut (
    .clk(clk), .rst_n(rst_n), .sample_clk_en(sample_clk_en), .key_on(key_on),
    .slot_req(slot_req), .phase_inc(phase_inc),
`ifdef PHASE_MOD_EN
    .phase_mod(phase_mod),
`endif
    .phase_out(phase_out), .phase_slot(phase_slot), .phase_valid(phase_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Monitor: cumulative capture of every phase_valid strobe plus busy/overrun counts
  int       cyc = 0;
  int       cap_n = 0;
  int       busy_cnt = 0;
  int       ovr_cnt = 0;
  logic [9:0] cap_out  [512];
  logic [4:0] cap_slot [512];
  int         cap_cyc  [512];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (phase_valid) begin
      if (cap_n < 512) begin
        cap_out[cap_n]  = phase_out;
        cap_slot[cap_n] = phase_slot;
        cap_cyc[cap_n]  = cyc;
      end
      cap_n = cap_n + 1;
    end
    if (busy)    busy_cnt = busy_cnt + 1;
    if (overrun) ovr_cnt  = ovr_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int fb, bb, ob;

  task automatic set_all_inc(input logic [19:0] v);
    for (int s = 0; s < NOPS; s++) inc_tab[s] = v;
  endtask

  // One frame; optional extra sample_clk_en at negedge index extra_at (0 = none)
  task automatic frame_run(input int extra_at);
    fb = cap_n; bb = busy_cnt; ob = ovr_cnt;
    @(negedge clk); sample_clk_en = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      sample_clk_en = (k == extra_at);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_end_busy got %b want 0", busy); end
    n_tests++;
    if (cap_n - fb != NOPS) begin n_fail++; $display("FAIL frame_valid_count got %0d want %0d", cap_n - fb, NOPS); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sample_clk_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({slot_req, phase_out, phase_slot, phase_valid, busy, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs req=%h out=%h slot=%h v=%b busy=%b ovr=%b want all 0",
               slot_req, phase_out, phase_slot, phase_valid, busy, overrun);
    end
    fb = cap_n; bb = busy_cnt;
    repeat (100) @(negedge clk);
    n_tests++;
    if (cap_n != fb) begin n_fail++; $display("FAIL idle_valid got %0d strobes want 0", cap_n - fb); end
    n_tests++;
    if (busy_cnt != bb) begin n_fail++; $display("FAIL idle_busy got %0d cycles want 0", busy_cnt - bb); end
  endtask

  task automatic test_const_frame();
    key_on = '0;
    set_all_inc(20'h00400);
    frame_run(0);
    n_tests++;
    if (busy_cnt - bb != 36) begin n_fail++; $display("FAIL const_busy_len got %0d want 36", busy_cnt - bb); end
    for (int k = 0; k < NOPS; k++) begin
      n_tests++;
      if (cap_slot[fb+k] !== 5'(k) || cap_out[fb+k] !== 10'h001) begin
        n_fail++;
        $display("FAIL const_slot%0d got slot=%0d out=%h want slot=%0d out=001", k, cap_slot[fb+k], cap_out[fb+k], k);
      end
      if (k > 0) begin
        n_tests++;
        if (cap_cyc[fb+k] - cap_cyc[fb+k-1] != 2) begin
          n_fail++; $display("FAIL const_spacing%0d got %0d want 2", k, cap_cyc[fb+k] - cap_cyc[fb+k-1]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    set_all_inc(20'h0);
    inc_tab[3] = 20'hFF800;            // 0x00400 + 0xFF800 = 0xFFC00
    frame_run(0);
    n_tests++;
    if (cap_out[fb+3] !== 10'h3FF) begin n_fail++; $display("FAIL wrap_pre got %h want 3ff", cap_out[fb+3]); end
    inc_tab[3] = 20'h00800;            // 0xFFC00 + 0x800 wraps to 0x00400
    frame_run(0);
    n_tests++;
    if (cap_out[fb+3] !== 10'h001) begin n_fail++; $display("FAIL wrap got %h want 001", cap_out[fb+3]); end
  endtask

  task automatic test_negative();
    set_all_inc(20'h0);
    key_on[0] = 1'b1;                  // key-on edge clears slot 0
    frame_run(0);
    n_tests++;
    if (cap_out[fb+0] !== 10'h000) begin n_fail++; $display("FAIL neg_clear got %h want 000", cap_out[fb+0]); end
    inc_tab[0] = 20'hFFC00;
    frame_run(0);
    n_tests++;
    if (cap_out[fb+0] !== 10'h3FF) begin n_fail++; $display("FAIL negative got %h want 3ff", cap_out[fb+0]); end
  endtask

  task automatic test_key_on();
    set_all_inc(20'h0);
    inc_tab[5] = 20'h11F45;            // 0x00400 + 0x11F45 = 0x12345
    frame_run(0);
    n_tests++;
    if (cap_out[fb+5] !== 10'h048) begin n_fail++; $display("FAIL ko_accum got %h want 048", cap_out[fb+5]); end
    key_on[5] = 1'b1;
    frame_run(0);
    n_tests++;
    if (cap_out[fb+5] !== 10'h000) begin n_fail++; $display("FAIL ko_edge got %h want 000", cap_out[fb+5]); end
    inc_tab[5] = 20'h00400;
    frame_run(0);
    n_tests++;
    if (cap_out[fb+5] !== 10'h001) begin n_fail++; $display("FAIL ko_held got %h want 001", cap_out[fb+5]); end
  endtask

  task automatic test_overrun();
    set_all_inc(20'h0);
    for (int pass = 0; pass < 2; pass++) begin
      frame_run(pass == 0 ? 10 : 36);  // mid-frame, then during the final WRITE
      n_tests++;
      if (ovr_cnt - ob != 1) begin n_fail++; $display("FAIL overrun%0d pulses got %0d want 1", pass, ovr_cnt - ob); end
      n_tests++;
      if (busy_cnt - bb != 36) begin n_fail++; $display("FAIL overrun%0d busy_len got %0d want 36", pass, busy_cnt - bb); end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    key_on = '0;
    set_all_inc(20'h0);
    fb = cap_n;
    @(negedge clk); sample_clk_en = 1'b1;
    for (int k = 1; k < 20; k++) begin @(negedge clk); sample_clk_en = 1'b0; end
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if (cap_n - fb != 9) begin n_fail++; $display("FAIL midrst_pre_valid got %0d want 9", cap_n - fb); end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n0 = cap_n; bb = busy_cnt;
    repeat (20) @(negedge clk);
    n_tests++;
    if (cap_n != n0 || busy_cnt != bb) begin
      n_fail++; $display("FAIL midrst_quiet got valid=%0d busy=%0d want 0 0", cap_n - n0, busy_cnt - bb);
    end
    set_all_inc(20'h00400);
    frame_run(0);
    for (int k = 0; k < NOPS; k++) begin
      n_tests++;
      if (cap_out[fb+k] !== 10'h001) begin n_fail++; $display("FAIL midrst_acc%0d got %h want 001", k, cap_out[fb+k]); end
    end
  endtask

`ifdef PHASE_MOD_EN
  task automatic test_phase_mod();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_all_inc(20'h0);
    phase_mod = -10'sd1;
    frame_run(0);
    for (int k = 0; k < NOPS; k++) begin
      n_tests++;
      if (cap_out[fb+k] !== 10'h3FF) begin n_fail++; $display("FAIL phase_mod%0d got %h want 3ff", k, cap_out[fb+k]); end
    end
    phase_mod = '0;
  endtask
`endif

  initial begin
    set_all_inc(20'h0);
    test_reset();
    test_const_frame();
    test_wrap();
    test_negative();
    test_key_on();
    test_overrun();
    test_reset_mid();
`ifdef PHASE_MOD_EN
    test_phase_mod();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
